// File: rtl/control_pipe_unit_if.sv
// Bundle of ID-stage inputs and per-stage control outputs of control_pipe_unit.
// The master side drives the decoded instruction fields, the slave side is the control unit.
interface control_pipe_unit_if #(
    parameter int NB_OP  = 6,
    parameter int NB_REG = 5,
    parameter int NB_CNT = 16
);
    logic              i_valid;
    logic [NB_OP-1:0]  i_opcode;
    logic [NB_OP-1:0]  i_funct;
    logic [NB_REG-1:0] i_rs;
    logic [NB_REG-1:0] i_rt;
    logic              i_stall;
    logic              i_flush;

    logic              o_hazard;

    logic              o_ex_valid;
    logic              o_ex_jump;
    logic              o_ex_link;
    logic              o_ex_branch;
    logic              o_ex_bne;
    logic              o_ex_regDst;
    logic              o_ex_immediate;
    logic              o_ex_illegal;
    logic [1:0]        o_ex_aluSrc;
    logic [1:0]        o_ex_aluOp;

    logic              o_mem_valid;
    logic              o_mem_memRead;
    logic              o_mem_memWrite;
    logic              o_mem_sign;
    logic [1:0]        o_mem_width;

    logic              o_wb_valid;
    logic              o_wb_regWrite;
    logic              o_wb_mem2Reg;

    logic [NB_CNT-1:0] o_retired;

    modport master (
        output i_valid, i_opcode, i_funct, i_rs, i_rt, i_stall, i_flush,
        input  o_hazard,
        input  o_ex_valid, o_ex_jump, o_ex_link, o_ex_branch, o_ex_bne,
               o_ex_regDst, o_ex_immediate, o_ex_illegal, o_ex_aluSrc, o_ex_aluOp,
        input  o_mem_valid, o_mem_memRead, o_mem_memWrite, o_mem_sign, o_mem_width,
        input  o_wb_valid, o_wb_regWrite, o_wb_mem2Reg,
        input  o_retired
    );

    modport slave (
        input  i_valid, i_opcode, i_funct, i_rs, i_rt, i_stall, i_flush,
        output o_hazard,
        output o_ex_valid, o_ex_jump, o_ex_link, o_ex_branch, o_ex_bne,
               o_ex_regDst, o_ex_immediate, o_ex_illegal, o_ex_aluSrc, o_ex_aluOp,
        output o_mem_valid, o_mem_memRead, o_mem_memWrite, o_mem_sign, o_mem_width,
        output o_wb_valid, o_wb_regWrite, o_wb_mem2Reg,
        output o_retired
    );
endinterface

// File: rtl/control_pipe_unit.sv
// Pipelined MIPS control unit: decodes in ID, carries control through ID/EX, EX/MEM, MEM/WB,
// inserts bubbles for load-use hazards and flushes, and counts retired instructions.
module control_pipe_unit #(
    parameter int NB_OP  = 6,
    parameter int NB_REG = 5,
    parameter int NB_CNT = 16
) (
    input logic                clk,
    input logic                i_reset,
    control_pipe_unit_if.slave bus
);

    localparam logic [NB_OP-1:0] OP_RTYPE = NB_OP'(6'b000000);
    localparam logic [NB_OP-1:0] OP_J     = NB_OP'(6'b000010);
    localparam logic [NB_OP-1:0] OP_JAL   = NB_OP'(6'b000011);
    localparam logic [NB_OP-1:0] OP_BEQ   = NB_OP'(6'b000100);
    localparam logic [NB_OP-1:0] OP_BNE   = NB_OP'(6'b000101);
    localparam logic [NB_OP-1:0] OP_ADDI  = NB_OP'(6'b001000);
    localparam logic [NB_OP-1:0] OP_ANDI  = NB_OP'(6'b001100);
    localparam logic [NB_OP-1:0] OP_ORI   = NB_OP'(6'b001101);
    localparam logic [NB_OP-1:0] OP_XORI  = NB_OP'(6'b001110);
    localparam logic [NB_OP-1:0] OP_LUI   = NB_OP'(6'b001111);
    localparam logic [NB_OP-1:0] OP_LB    = NB_OP'(6'b100000);
    localparam logic [NB_OP-1:0] OP_LH    = NB_OP'(6'b100001);
    localparam logic [NB_OP-1:0] OP_LW    = NB_OP'(6'b100011);
    localparam logic [NB_OP-1:0] OP_LBU   = NB_OP'(6'b100100);
    localparam logic [NB_OP-1:0] OP_LHU   = NB_OP'(6'b100101);
    localparam logic [NB_OP-1:0] OP_SB    = NB_OP'(6'b101000);
    localparam logic [NB_OP-1:0] OP_SH    = NB_OP'(6'b101001);
    localparam logic [NB_OP-1:0] OP_SW    = NB_OP'(6'b101011);

    localparam logic [NB_OP-1:0] FN_JR    = NB_OP'(6'b001000);
    localparam logic [NB_OP-1:0] FN_JALR  = NB_OP'(6'b001001);

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_LOGIC = 2'b11;

    localparam logic [1:0] SRC_SEXT  = 2'b01;
    localparam logic [1:0] SRC_ZEXT  = 2'b10;
    localparam logic [1:0] SRC_UPPER = 2'b11;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b11;

    typedef struct packed {
        logic       valid;
        logic       jump;
        logic       link;
        logic       branch;
        logic       bne;
        logic       regDst;
        logic       immediate;
        logic       illegal;
        logic [1:0] aluSrc;
        logic [1:0] aluOp;
        logic       memRead;
        logic       memWrite;
        logic       sign;
        logic [1:0] width;
        logic       regWrite;
        logic       mem2Reg;
    } ctrl_t;

    typedef struct packed {
        ctrl_t             ctrl;
        logic [NB_REG-1:0] rt;
    } idEx_t;

    typedef struct packed {
        logic       valid;
        logic       memRead;
        logic       memWrite;
        logic       sign;
        logic [1:0] width;
        logic       regWrite;
        logic       mem2Reg;
    } exMem_t;

    typedef struct packed {
        logic valid;
        logic regWrite;
        logic mem2Reg;
    } memWb_t;

    ctrl_t             decoded;
    logic              hazard;
    idEx_t             idEx_q,    idEx_d;
    exMem_t            exMem_q,   exMem_d;
    memWb_t            memWb_q,   memWb_d;
    logic [NB_CNT-1:0] retired_q, retired_d;

    // Combinational decode; an empty ID slot yields an all-zero bundle, never an illegal flag.
    always_comb begin
        decoded = '0;
        if (bus.i_valid) begin
            decoded.valid = 1'b1;
            case (bus.i_opcode)
                OP_RTYPE: begin
                    decoded.regDst   = 1'b1;
                    decoded.regWrite = 1'b1;
                    decoded.aluOp    = ALU_FUNCT;
                    if (bus.i_funct == FN_JR) begin
                        decoded.jump     = 1'b1;
                        decoded.regWrite = 1'b0;
                    end else if (bus.i_funct == FN_JALR) begin
                        decoded.jump = 1'b1;
                        decoded.link = 1'b1;
                    end
                end
                OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: begin
                    decoded.memRead  = 1'b1;
                    decoded.mem2Reg  = 1'b1;
                    decoded.regWrite = 1'b1;
                    decoded.aluSrc   = SRC_SEXT;
                    case (bus.i_opcode)
                        OP_LW:   begin decoded.width = W_WORD; decoded.sign = 1'b1; end
                        OP_LH:   begin decoded.width = W_HALF; decoded.sign = 1'b1; end
                        OP_LHU:  decoded.width = W_HALF;
                        OP_LB:   begin decoded.width = W_BYTE; decoded.sign = 1'b1; end
                        default: decoded.width = W_BYTE;
                    endcase
                end
                OP_SW, OP_SH, OP_SB: begin
                    decoded.memWrite = 1'b1;
                    decoded.aluSrc   = SRC_SEXT;
                    case (bus.i_opcode)
                        OP_SW:   decoded.width = W_WORD;
                        OP_SH:   decoded.width = W_HALF;
                        default: decoded.width = W_BYTE;
                    endcase
                end
                OP_BEQ: begin
                    decoded.branch = 1'b1;
                    decoded.aluOp  = ALU_SUB;
                end
                OP_BNE: begin
                    decoded.branch = 1'b1;
                    decoded.bne    = 1'b1;
                    decoded.aluOp  = ALU_SUB;
                end
                OP_ADDI: begin
                    decoded.regWrite  = 1'b1;
                    decoded.immediate = 1'b1;
                    decoded.aluSrc    = SRC_SEXT;
                    decoded.aluOp     = ALU_ADD;
                end
                OP_ANDI, OP_ORI, OP_XORI: begin
                    decoded.regWrite  = 1'b1;
                    decoded.immediate = 1'b1;
                    decoded.aluSrc    = SRC_ZEXT;
                    decoded.aluOp     = ALU_LOGIC;
                end
                OP_LUI: begin
                    decoded.regWrite  = 1'b1;
                    decoded.immediate = 1'b1;
                    decoded.aluSrc    = SRC_UPPER;
                    decoded.aluOp     = ALU_LOGIC;
                end
                OP_J: begin
                    decoded.jump = 1'b1;
                end
                OP_JAL: begin
                    decoded.jump     = 1'b1;
                    decoded.link     = 1'b1;
                    decoded.regWrite = 1'b1;
                end
                default: begin
                    decoded.illegal = 1'b1;
                end
            endcase
        end
    end

    // Register 0 is never written, so a load targeting it cannot create a dependency.
    assign hazard = bus.i_valid
                  & idEx_q.ctrl.valid
                  & idEx_q.ctrl.memRead
                  & (idEx_q.rt != '0)
                  & ((idEx_q.rt == bus.i_rs) | (idEx_q.rt == bus.i_rt));

    // Stage advance: a stall freezes everything; otherwise flush beats hazard when choosing a bubble.
    always_comb begin
        idEx_d    = idEx_q;
        exMem_d   = exMem_q;
        memWb_d   = memWb_q;
        retired_d = retired_q;
        if (!bus.i_stall) begin
            if (bus.i_flush || hazard) begin
                idEx_d = '0;
            end else begin
                idEx_d.ctrl = decoded;
                idEx_d.rt   = bus.i_rt;
            end

            exMem_d.valid    = idEx_q.ctrl.valid;
            exMem_d.memRead  = idEx_q.ctrl.memRead;
            exMem_d.memWrite = idEx_q.ctrl.memWrite;
            exMem_d.sign     = idEx_q.ctrl.sign;
            exMem_d.width    = idEx_q.ctrl.width;
            exMem_d.regWrite = idEx_q.ctrl.regWrite;
            exMem_d.mem2Reg  = idEx_q.ctrl.mem2Reg;

            memWb_d.valid    = exMem_q.valid;
            memWb_d.regWrite = exMem_q.regWrite;
            memWb_d.mem2Reg  = exMem_q.mem2Reg;

            if (memWb_q.valid) begin
                retired_d = retired_q + NB_CNT'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            idEx_q    <= '0;
            exMem_q   <= '0;
            memWb_q   <= '0;
            retired_q <= '0;
        end else begin
            idEx_q    <= idEx_d;
            exMem_q   <= exMem_d;
            memWb_q   <= memWb_d;
            retired_q <= retired_d;
        end
    end

    assign bus.o_hazard       = hazard;

    assign bus.o_ex_valid     = idEx_q.ctrl.valid;
    assign bus.o_ex_jump      = idEx_q.ctrl.jump;
    assign bus.o_ex_link      = idEx_q.ctrl.link;
    assign bus.o_ex_branch    = idEx_q.ctrl.branch;
    assign bus.o_ex_bne       = idEx_q.ctrl.bne;
    assign bus.o_ex_regDst    = idEx_q.ctrl.regDst;
    assign bus.o_ex_immediate = idEx_q.ctrl.immediate;
    assign bus.o_ex_illegal   = idEx_q.ctrl.illegal;
    assign bus.o_ex_aluSrc    = idEx_q.ctrl.aluSrc;
    assign bus.o_ex_aluOp     = idEx_q.ctrl.aluOp;

    assign bus.o_mem_valid    = exMem_q.valid;
    assign bus.o_mem_memRead  = exMem_q.memRead;
    assign bus.o_mem_memWrite = exMem_q.memWrite;
    assign bus.o_mem_sign     = exMem_q.sign;
    assign bus.o_mem_width    = exMem_q.width;

    assign bus.o_wb_valid     = memWb_q.valid;
    assign bus.o_wb_regWrite  = memWb_q.regWrite;
    assign bus.o_wb_mem2Reg   = memWb_q.mem2Reg;

    assign bus.o_retired      = retired_q;

endmodule
